// File: rtl/bp_dma_mem_responder.sv
// ============================================================================
// Module   : bp_dma_mem_responder
// Brief    : Block-granular DMA memory responder with an internal fill-width
//            array; serves bsg_cache read/write block transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_dma_mem_responder #(
    parameter int caddr_width_p        = 28,
    parameter int fill_width_p         = 64,
    parameter int block_size_in_fill_p = 8,
    parameter int mem_els_p            = 4096
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [caddr_width_p:0]  dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,

    output logic [fill_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,

    input  logic [fill_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o
);

    localparam int c_byte_off = $clog2(fill_width_p / 8);
    localparam int c_cnt_w    = $clog2(block_size_in_fill_p);
    localparam int c_idx_w    = $clog2(mem_els_p);
    localparam int c_blk_w    = c_idx_w - c_cnt_w;

    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(block_size_in_fill_p - 1);

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_read  = 2'd1,
        e_write = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_blk_w-1:0]   r_blk;
    logic [c_blk_w-1:0]   w_blk_nxt;

    logic [c_blk_w-1:0]   w_pkt_blk;
    logic [c_idx_w-1:0]   w_mem_idx;
    logic                 w_pkt_yumi;
    logic                 w_data_v;
    logic                 w_data_yumi;
    logic                 w_mem_we;
    logic                 w_unused_pkt;

    logic [fill_width_p-1:0] r_mem [mem_els_p];

    // Block index: drop byte offset, drop beat bits, wrap modulo array size.
    assign w_pkt_blk    = dma_pkt_i[c_byte_off+c_idx_w-1 : c_byte_off+c_cnt_w];
    assign w_unused_pkt = ^dma_pkt_i;
    assign w_mem_idx    = {r_blk, r_cnt};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_ready;
            r_cnt   <= '0;
            r_blk   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_blk   <= w_blk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_blk_nxt   = r_blk;
        w_pkt_yumi  = 1'b0;
        w_data_v    = 1'b0;
        w_data_yumi = 1'b0;
        w_mem_we    = 1'b0;

        case (r_state)
            e_ready: begin
                w_pkt_yumi = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    w_blk_nxt   = w_pkt_blk;
                    w_cnt_nxt   = '0;
                    w_state_nxt = dma_pkt_i[caddr_width_p] ? e_write : e_read;
                end
            end
            e_read: begin
                w_data_v = 1'b1;
                if (dma_data_ready_and_i) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_last_beat) begin
                        w_state_nxt = e_ready;
                    end
                end
            end
            e_write: begin
                w_data_yumi = dma_data_v_i;
                if (dma_data_v_i) begin
                    w_mem_we  = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_last_beat) begin
                        w_state_nxt = e_ready;
                    end
                end
            end
            default: begin
                w_state_nxt = e_ready;
            end
        endcase
    end

    // Handshakes are forced low for the whole time reset is held.
    assign dma_pkt_yumi_o  = reset_n_i & w_pkt_yumi;
    assign dma_data_v_o    = reset_n_i & w_data_v;
    assign dma_data_yumi_o = reset_n_i & w_data_yumi;
    assign dma_data_o      = r_mem[w_mem_idx];

    // Array is intentionally outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= dma_data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_dma_mem_responder.sv
// ============================================================================
// Module   : tb_bp_dma_mem_responder
// Brief    : Directed self-checking bench for bp_dma_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_dma_mem_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [28:0] dma_pkt_i;
    logic        dma_pkt_v_i;
    logic        dma_pkt_yumi_o;
    logic [63:0] dma_data_o;
    logic        dma_data_v_o;
    logic        dma_data_ready_and_i;
    logic [63:0] dma_data_i;
    logic        dma_data_v_i;
    logic        dma_data_yumi_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    bp_dma_mem_responder #(
        .caddr_width_p        (28),
        .fill_width_p         (64),
        .block_size_in_fill_p (8),
        .mem_els_p            (4096)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_yumi_o       (dma_pkt_yumi_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_yumi_o      (dma_data_yumi_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Entered one tick after the edge that consumed the read packet. Serves
    // n_beats beats expecting base_val+i; beat stall_beat is held stall_n
    // cycles. With busy set, a packet and a write beat are offered throughout.
    task automatic read_beats(input int n_beats, input logic [63:0] base_val,
                              input int stall_beat, input int stall_n, input logic busy);
        int beat  = 0;
        int stall = 0;
        int cyc   = 0;
        while (beat < n_beats && cyc < 40) begin
            dma_data_ready_and_i = !(beat == stall_beat && stall < stall_n);
            dma_data_v_i         = busy;
            dma_data_i           = 64'hDEAD_BEEF_0000_0000;
            @(negedge clk_i);
            check("rd_v", 64'(dma_data_v_o), 64'd1);
            check("rd_data", dma_data_o, base_val + 64'(beat));
            if (busy) begin
                check("busy_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
                check("busy_data_yumi", 64'(dma_data_yumi_o), 64'd0);
            end
            if (dma_data_ready_and_i) beat++;
            else stall++;
            cyc++;
            next_cycle();
        end
        check("rd_beats_done", 64'(beat), 64'(n_beats));
        dma_data_ready_and_i = 1'b0;
        dma_data_v_i         = 1'b0;
    endtask

    initial begin
        int beat;
        int yumis;
        int cyc;
        logic gap3;
        logic gap5;
        logic gap;

        // Reset held with both valids asserted: every handshake stays low.
        reset_n_i            = 1'b0;
        dma_pkt_i            = {1'b1, 28'h40};
        dma_pkt_v_i          = 1'b1;
        dma_data_ready_and_i = 1'b0;
        dma_data_i           = 64'h0;
        dma_data_v_i         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rst_outs", 64'({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o}), 64'd0);
        end
        next_cycle();
        reset_n_i    = 1'b1;
        dma_data_v_i = 1'b0;
        @(negedge clk_i);
        check("rst_release_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        next_cycle();
        dma_pkt_v_i = 1'b0;

        // Write block 0x40 -> mem[8..15], gap cycles before beats 3 and 5.
        beat = 0; yumis = 0; cyc = 0; gap3 = 1'b0; gap5 = 1'b0;
        while (beat < 8 && cyc < 20) begin
            gap          = (beat == 3 && !gap3) || (beat == 5 && !gap5);
            dma_data_v_i = !gap;
            dma_data_i   = 64'h1000 + 64'(beat);
            @(negedge clk_i);
            check("wr_yumi", 64'(dma_data_yumi_o), 64'(!gap));
            check("wr_no_rd_v", 64'(dma_data_v_o), 64'd0);
            yumis += int'(dma_data_yumi_o);
            if (gap && beat == 3) gap3 = 1'b1;
            else if (gap && beat == 5) gap5 = 1'b1;
            else beat++;
            cyc++;
            next_cycle();
        end
        check("wr_yumi_total", 64'(yumis), 64'd8);
        check("wr_cycles", 64'(cyc), 64'd10);
        // Back in e_ready: a stray write beat gets no yumi.
        dma_data_v_i = 1'b1;
        @(negedge clk_i);
        check("wr_done_ready", 64'(dma_data_yumi_o), 64'd0);
        next_cycle();

        // Read block 0x40 with a 3-cycle stall on beat 2.
        dma_data_v_i = 1'b0;
        dma_pkt_i    = {1'b0, 28'h40};
        dma_pkt_v_i  = 1'b1;
        @(negedge clk_i);
        check("rd_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        check("rd_pkt_cycle_v", 64'(dma_data_v_o), 64'd0);
        next_cycle();
        dma_pkt_v_i = 1'b0;
        read_beats(8, 64'h1000, 2, 3, 1'b0);
        @(negedge clk_i);
        check("rd_done_v", 64'(dma_data_v_o), 64'd0);
        next_cycle();

        // Aliased, unaligned read 0x8058 -> block at word 8; a second packet
        // and write beats are offered throughout and must be ignored.
        dma_pkt_i   = {1'b0, 28'h8058};
        dma_pkt_v_i = 1'b1;
        @(negedge clk_i);
        check("alias_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        next_cycle();
        dma_pkt_i = {1'b0, 28'h48};
        read_beats(8, 64'h1000, -1, 0, 1'b1);
        @(negedge clk_i);
        check("busy_next_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        next_cycle();
        dma_pkt_v_i = 1'b0;
        read_beats(8, 64'h1000, -1, 0, 1'b0);

        // Reset in the middle of a read, after 3 beats.
        dma_pkt_i   = {1'b0, 28'h40};
        dma_pkt_v_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        next_cycle();
        dma_pkt_v_i = 1'b0;
        read_beats(3, 64'h1000, -1, 0, 1'b0);
        #1;
        check("rstmid_pre_v", 64'(dma_data_v_o), 64'd1);
        check("rstmid_pre_data", dma_data_o, 64'h1003);
        reset_n_i = 1'b0;
        #1;
        check("rstmid_v_drop", 64'(dma_data_v_o), 64'd0);
        next_cycle();
        next_cycle();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_idle_v", 64'(dma_data_v_o), 64'd0);
        next_cycle();
        dma_pkt_v_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_fresh_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        next_cycle();
        dma_pkt_v_i = 1'b0;
        read_beats(8, 64'h1000, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
